// File: rtl/soc_pkg.sv
// Shared constants for the SoC memory/IO slave: address decode, IO register
// selects, UART status bit positions and the UART transmitter state encoding.
package soc_pkg;

  localparam int unsigned IO_PAGE_BIT = 22;

  localparam logic [2:0] REG_LEDS        = 3'd0;
  localparam logic [2:0] REG_UART_DATA   = 3'd1;
  localparam logic [2:0] REG_UART_STATUS = 3'd2;

  localparam int unsigned ST_FULL = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_OVF  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/soc_mem_io_if.sv
// Core-side memory bus: byte address, one-cycle read strobe, lane-replicated
// write data with byte-lane mask, and registered read data.
interface soc_mem_io_if;

  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_rstrb,
    output mem_wdata,
    output mem_wmask,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rstrb,
    input  mem_wdata,
    input  mem_wmask,
    output mem_rdata
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter. Writes while full are dropped and
// flagged on overflow_set for one cycle; the sticky flag lives in the parent.
module uart_tx_fifo
  import soc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow_set,
  output logic       tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW = PW - 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic          w_empty, w_full, w_push, w_pop;

  uart_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty      = (r_wp == r_rp);
  assign w_full       = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push       = wr_en & ~w_full;
  assign overflow_set = wr_en & w_full;
  assign full         = w_full;
  assign busy         = ~w_empty | (r_state != StIdle);
  assign tx           = r_tx;

  // FIFO storage, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= wr_data;
    end
  end

  // TX next state; r_tx is loaded with the level of the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rp[AW-1:0]];
          w_cnt_nxt   = '0;
          w_state_nxt = StStart;
          w_tx_nxt    = 1'b0;
        end
      end
      StStart: begin
        if (r_cnt == CNT_MAX) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StData;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      StData: begin
        if (r_cnt == CNT_MAX) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = StStop;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      StStop: begin
        if (r_cnt == CNT_MAX) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, pointers and line register; reset flushes the FIFO and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
    end
  end

endmodule

// File: rtl/soc_mem_io.sv
// Memory and peripheral slave behind the RV32I core: word RAM with byte-lane
// writes, LED register and UART TX page. Read data is registered.
module soc_mem_io
  import soc_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1536,
  parameter string       INIT_FILE    = "firmware.hex",
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  soc_mem_io_if.slave  bus,
  output logic [4:0]   leds,
  output logic         uart_tx
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] r_ram [DEPTH];
  logic [31:0] r_rdata;
  logic [4:0]  r_leds;
  logic        r_ovf;

  logic          w_io;
  logic [2:0]    w_sel;
  logic [AW-1:0] w_idx;
  logic          w_ram_we, w_io_we, w_led_we, w_uart_we, w_stat_rd;
  logic          w_full, w_busy, w_ovf_set, w_ovf_nxt;
  logic [31:0]   w_status, w_rdata_nxt;
  logic          w_unused_addr;

  // High address bits beyond the RAM index are don't-care (the RAM wraps).
  assign w_unused_addr = ^bus.mem_addr;

  assign w_io      = bus.mem_addr[IO_PAGE_BIT];
  assign w_sel     = bus.mem_addr[4:2];
  assign w_idx     = bus.mem_addr[AW+1:2];
  assign w_ram_we  = (|bus.mem_wmask) & ~w_io;
  assign w_io_we   = w_io & bus.mem_wmask[0];
  assign w_led_we  = w_io_we & (w_sel == REG_LEDS);
  assign w_uart_we = w_io_we & (w_sel == REG_UART_DATA);
  assign w_stat_rd = bus.mem_rstrb & w_io & (w_sel == REG_UART_STATUS);
  // A same-cycle overflow survives the clearing status read.
  assign w_ovf_nxt = (r_ovf & ~w_stat_rd) | w_ovf_set;

  assign bus.mem_rdata = r_rdata;
  assign leds          = r_leds;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (w_uart_we),
    .wr_data      (bus.mem_wdata[7:0]),
    .full         (w_full),
    .busy         (w_busy),
    .overflow_set (w_ovf_set),
    .tx           (uart_tx)
  );

  // Byte-lane RAM write; non-blocking gives read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wmask[b]) r_ram[w_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  // Read mux: RAM word or IO register selected by the page bit.
  always_comb begin
    w_status          = '0;
    w_status[ST_FULL] = w_full;
    w_status[ST_BUSY] = w_busy;
    w_status[ST_OVF]  = r_ovf;
    w_rdata_nxt       = '0;
    if (!w_io) begin
      w_rdata_nxt = r_ram[w_idx];
    end else begin
      case (w_sel)
        REG_LEDS:        w_rdata_nxt = {27'd0, r_leds};
        REG_UART_STATUS: w_rdata_nxt = w_status;
        default:         w_rdata_nxt = '0;
      endcase
    end
  end

  // Registered read data, LED register and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_leds  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.mem_rstrb) r_rdata <= w_rdata_nxt;
      if (w_led_we)      r_leds  <= bus.mem_wdata[4:0];
      r_ovf <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_soc_mem_io.sv
// Self-checking bench for soc_mem_io: a transaction/frame-level model is
// stepped on every clock edge and compared with the DUT on every falling edge,
// alongside hand-computed literal expectations.
module tb_soc_mem_io;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FD    = 4;
  localparam int unsigned MW    = 1536;
  localparam int unsigned MAW   = $clog2(MW);
  localparam int unsigned RAM_D = 1 << MAW;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] leds;
  logic       uart_tx;

  soc_mem_io_if bus();

  soc_mem_io #(
    .MEM_WORDS    (MW),
    .INIT_FILE    (""),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .leds    (leds),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [31:0]  m_ram [RAM_D];
  logic [31:0]  m_rdata;
  logic [4:0]   m_leds;
  bit           m_ovf;
  byte unsigned m_fifo[$];
  bit           m_line[$];
  bit           m_active;
  bit           m_tx;

  int frames;
  int rx_skip;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rdata  = '0;
    m_leds   = '0;
    m_ovf    = 1'b0;
    m_fifo.delete();
    m_line.delete();
    m_active = 1'b0;
    m_tx     = 1'b1;
  endtask

  // Whole 8N1 frame as per-cycle line levels; first level appears right away.
  task automatic start_frame(input byte unsigned b);
    bit v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) v = 1'b0;
      else if (k == 9) v = 1'b1;
      else v = b[k-1];
      for (int c = 0; c < int'(CPB); c++) m_line.push_back(v);
    end
    m_tx     = m_line.pop_front();
    m_active = 1'b1;
  endtask

  task automatic model_step();
    int          idx;
    logic [2:0]  sel;
    bit          io, full, busy, wr, ovf_set;
    logic [31:0] rd;
    idx     = int'(bus.mem_addr[MAW+1:2]);
    sel     = bus.mem_addr[4:2];
    io      = bus.mem_addr[22];
    full    = (m_fifo.size() == FD);
    busy    = (m_fifo.size() != 0) || m_active;
    wr      = 1'b0;
    ovf_set = 1'b0;
    if (bus.mem_rstrb) begin
      rd = '0;
      if (!io) rd = m_ram[idx];
      else if (sel == 3'd0) rd = {27'd0, m_leds};
      else if (sel == 3'd2) rd = {29'd0, m_ovf, busy, full};
      m_rdata = rd;
    end
    if (bus.mem_wmask != 4'd0) begin
      if (!io) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) m_ram[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end else if (bus.mem_wmask[0]) begin
        if (sel == 3'd0) m_leds = bus.mem_wdata[4:0];
        if (sel == 3'd1) wr = 1'b1;
      end
    end
    // Transmitter: finish current frame, then one idle cycle, then next byte.
    if (m_active) begin
      if (m_line.size() > 0) m_tx = m_line.pop_front();
      else begin
        m_active = 1'b0;
        m_tx     = 1'b1;
      end
    end else if (m_fifo.size() > 0) begin
      start_frame(m_fifo.pop_front());
    end
    if (wr) begin
      if (full) ovf_set = 1'b1;
      else m_fifo.push_back(bus.mem_wdata[7:0]);
    end
    if (bus.mem_rstrb && io && sel == 3'd2) m_ovf = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
  endtask

  // One clock: step model on the rising edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    if (!rst) begin
      chk("model_rdata", bus.mem_rdata, m_rdata);
      chk("model_leds", leds, m_leds);
      chk("model_uart_tx", uart_tx, m_tx);
    end
    if (rx_skip > 0) rx_skip--;
    else if (uart_tx == 1'b0) begin
      frames++;
      rx_skip = 10 * CPB - 1;
    end
  endtask

  task automatic bus_idle();
    bus.mem_rstrb = 1'b0;
    bus.mem_wmask = 4'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wmask = m;
    bus.mem_rstrb = 1'b0;
    cyc();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_addr  = a;
    bus.mem_rstrb = 1'b1;
    bus.mem_wmask = 4'd0;
    cyc();
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0]  frame;
    logic [39:0] cap, exp_cap;

    frames  = 0;
    rx_skip = 0;
    for (int i = 0; i < int'(RAM_D); i++) m_ram[i] = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus_idle();
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;

    // Reset values
    chk("reset_rdata", bus.mem_rdata, 32'h0);
    chk("reset_leds", leds, 5'h0);
    chk("reset_uart_tx", uart_tx, 1'b1);

    // Fetch: rdata stays 0 until the strobe edge
    wr(32'h0, 32'h0000_0013, 4'hF);
    chk("prefetch_rdata", bus.mem_rdata, 32'h0);
    rd(32'h0);
    chk("fetch_word0", bus.mem_rdata, 32'h0000_0013);
    cyc();
    chk("rdata_hold", bus.mem_rdata, 32'h0000_0013);

    // Byte-lane write
    wr(32'h10, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'hAAAA_AAAA, 4'b0100);
    rd(32'h10);
    chk("byte_lane", bus.mem_rdata, 32'h11AA_3344);

    // Read-before-write on the same word
    bus.mem_addr  = 32'h10;
    bus.mem_wdata = 32'h5555_5555;
    bus.mem_wmask = 4'hF;
    bus.mem_rstrb = 1'b1;
    cyc();
    bus_idle();
    chk("read_before_write", bus.mem_rdata, 32'h11AA_3344);
    rd(32'h10);
    chk("after_collision", bus.mem_rdata, 32'h5555_5555);

    // RAM wrap: 1536 words round to 2048, so 0x2000 aliases 0x0000
    wr(32'h2000, 32'hDEAD_BEEF, 4'hF);
    rd(32'h0);
    chk("ram_wrap", bus.mem_rdata, 32'hDEAD_BEEF);

    // LED register
    wr(32'h0040_0000, 32'h0000_001F, 4'hF);
    chk("leds_write", leds, 5'h1F);
    rd(32'h0040_0000);
    chk("leds_read", bus.mem_rdata, 32'h0000_001F);
    wr(32'h0040_0000, 32'h0000_0000, 4'b0010);
    chk("leds_mask_ignored", leds, 5'h1F);
    rd(32'h0040_0004);
    chk("uart_data_reads0", bus.mem_rdata, 32'h0);
    wr(32'h0040_0004, 32'h0000_0041, 4'b0010);
    rd(32'h0040_0014);
    chk("unused_sel_reads0", bus.mem_rdata, 32'h0);
    rd(32'h0040_0008);
    chk("status_idle", bus.mem_rdata, 32'h0);

    // Single UART frame of 8'hA5
    frames = 0;
    wr(32'h0040_0004, 32'h0000_00A5, 4'b0001);
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        bus.mem_addr  = 32'h0040_0008;
        bus.mem_rstrb = 1'b1;
      end
      cyc();
      if (i == 20) begin
        bus_idle();
        chk("status_busy_mid", bus.mem_rdata, 32'h2);
      end
      cap[i] = uart_tx;
    end
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) exp_cap[i] = frame[i/4];
    chk("frame_a5", cap, exp_cap);
    chk("frame_a5_count", frames, 1);
    cyc();
    rd(32'h0040_0008);
    chk("status_after_frame", bus.mem_rdata, 32'h0);

    // FIFO overflow: one popped, four buffered, sixth dropped
    frames = 0;
    for (int i = 0; i < 6; i++) wr(32'h0040_0004, 32'h30 + i, 4'b0001);
    rd(32'h0040_0008);
    chk("status_overflow", bus.mem_rdata, 32'h7);
    rd(32'h0040_0008);
    chk("status_ovf_cleared", bus.mem_rdata, 32'h3);
    repeat (300) cyc();
    chk("overflow_frames", frames, 5);
    rd(32'h0040_0008);
    chk("status_drained", bus.mem_rdata, 32'h0);

    // Asynchronous reset in the middle of a frame
    wr(32'h0040_0000, 32'h0000_0015, 4'hF);
    wr(32'h0040_0004, 32'h0000_0000, 4'b0001);
    wr(32'h0040_0004, 32'h0000_0012, 4'b0001);
    wr(32'h0040_0004, 32'h0000_0034, 4'b0001);
    repeat (12) cyc();
    chk("tx_low_in_data", uart_tx, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_tx", uart_tx, 1'b1);
    chk("async_rst_leds", leds, 5'h0);
    chk("async_rst_rdata", bus.mem_rdata, 32'h0);
    cyc();
    cyc();
    rst     = 1'b0;
    frames  = 0;
    rx_skip = 0;
    rd(32'h0040_0008);
    chk("status_after_rst", bus.mem_rdata, 32'h0);
    repeat (60) cyc();
    chk("no_frames_after_rst", frames, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
